// File: rtl/simon_seq_pkg.sv
// Shared types and constants for the Simon top-level sequencer.
package simon_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CRYPT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_LOAD  = 2'd1;
    localparam logic [1:0] PH_CRYPT = 2'd2;
    localparam logic [1:0] PH_DRAIN = 2'd3;

    localparam int unsigned CNT_W_DEF    = 10;
    localparam int unsigned LOAD_TO_DEF  = 64;
    localparam int unsigned CRYPT_TO_DEF = 512;
    localparam int unsigned DRAIN_TO_DEF = 64;
    localparam int unsigned BLK_W_DEF    = 4;

    // True for the three watched working phases.
    function automatic logic is_active(state_e s);
        return (s == ST_LOAD) || (s == ST_CRYPT) || (s == ST_DRAIN);
    endfunction

    // Error-phase code reported when state s times out.
    function automatic logic [1:0] phase_of(state_e s);
        logic [1:0] ph;
        case (s)
            ST_LOAD:  ph = PH_LOAD;
            ST_CRYPT: ph = PH_CRYPT;
            ST_DRAIN: ph = PH_DRAIN;
            default:  ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/simon_seq_wdog.sv
// Per-phase watchdog: cycle counter with clear, enable, limit and terminal flag.
module simon_seq_wdog
    import simon_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Terminal while counting and on the last allowed cycle of the phase.
    assign term_o = en_i && (cnt_q == (limit_i - CNT_W'(1)));

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon top-level sequencer: LOAD -> CRYPT -> DRAIN -> DONE with watchdogs,
// abort, completed-block counter and state debug bus.
// Optional: define SIMON_SEQ_AUTORESTART_EN to go DONE -> LOAD while start is high.
module simon_seq_ctrl
    import simon_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned LOAD_TO  = LOAD_TO_DEF,
    parameter int unsigned CRYPT_TO = CRYPT_TO_DEF,
    parameter int unsigned DRAIN_TO = DRAIN_TO_DEF,
    parameter int unsigned BLK_W    = BLK_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_done,
    input  logic             core_done,
    input  logic             out_done,
    input  logic             txt_done,
    output logic             in_en,
    output logic             core_start,
    output logic             out_start,
    output logic             busy,
    output logic             blk_done,
    output logic             err,
    output logic [1:0]       err_phase,
    output logic [BLK_W-1:0] blk_cnt,
    output logic [2:0]       state_dbg
);

    state_e           state_q, state_d;
    logic             start_q;
    logic             out_seen_q, out_seen_d;
    logic             txt_seen_q, txt_seen_d;
    logic             in_en_q, in_en_d;
    logic             core_start_q, core_start_d;
    logic             out_start_q, out_start_d;
    logic             busy_q, busy_d;
    logic             blk_done_q, blk_done_d;
    logic             err_q, err_d;
    logic [1:0]       err_phase_q, err_phase_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;

    logic             start_rise;
    logic             drain_all;
    logic             wd_clr, wd_en, wd_term;
    logic [CNT_W-1:0] wd_limit;

    assign start_rise = start & ~start_q;
    // A done arriving this cycle counts together with an already latched one.
    assign drain_all  = (out_seen_q | out_done) & (txt_seen_q | txt_done);

    // Select the timeout of the phase currently being watched.
    always_comb begin
        case (state_q)
            ST_CRYPT: wd_limit = CNT_W'(CRYPT_TO);
            ST_DRAIN: wd_limit = CNT_W'(DRAIN_TO);
            default:  wd_limit = CNT_W'(LOAD_TO);
        endcase
    end

    assign wd_en  = is_active(state_q);
    assign wd_clr = abort | (state_d != state_q);

    simon_seq_wdog #(
        .CNT_W(CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (wd_clr),
        .en_i   (wd_en),
        .limit_i(wd_limit),
        .term_o (wd_term)
    );

    // Next-state logic; the phase event beats a coinciding timeout, abort beats all.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_done)      state_d = ST_CRYPT;
                else if (wd_term) state_d = ST_ERR;
            end
            ST_CRYPT: begin
                if (core_done)    state_d = ST_DRAIN;
                else if (wd_term) state_d = ST_ERR;
            end
            ST_DRAIN: begin
                if (drain_all)    state_d = ST_DONE;
                else if (wd_term) state_d = ST_ERR;
            end
            ST_DONE: begin
`ifdef SIMON_SEQ_AUTORESTART_EN
                state_d = start ? ST_LOAD : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Registered outputs are derived from the upcoming state so they align with it.
    always_comb begin
        in_en_d      = (state_d == ST_LOAD);
        busy_d       = is_active(state_d);
        core_start_d = (state_q == ST_LOAD)  && (state_d == ST_CRYPT);
        out_start_d  = (state_q == ST_CRYPT) && (state_d == ST_DRAIN);
        blk_done_d   = (state_d == ST_DONE);
        blk_cnt_d    = blk_done_d ? (blk_cnt_q + BLK_W'(1)) : blk_cnt_q;
        err_d        = (state_d == ST_ERR);
        err_phase_d  = PH_NONE;
        if (state_d == ST_ERR) begin
            err_phase_d = (state_q == ST_ERR) ? err_phase_q : phase_of(state_q);
        end
        out_seen_d = 1'b0;
        txt_seen_d = 1'b0;
        if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
            out_seen_d = out_seen_q | out_done;
            txt_seen_d = txt_seen_q | txt_done;
        end
    end

    // State, edge-detect, drain latches and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            out_seen_q   <= 1'b0;
            txt_seen_q   <= 1'b0;
            in_en_q      <= 1'b0;
            core_start_q <= 1'b0;
            out_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            blk_done_q   <= 1'b0;
            err_q        <= 1'b0;
            err_phase_q  <= '0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            out_seen_q   <= out_seen_d;
            txt_seen_q   <= txt_seen_d;
            in_en_q      <= in_en_d;
            core_start_q <= core_start_d;
            out_start_q  <= out_start_d;
            busy_q       <= busy_d;
            blk_done_q   <= blk_done_d;
            err_q        <= err_d;
            err_phase_q  <= err_phase_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign in_en      = in_en_q;
    assign core_start = core_start_q;
    assign out_start  = out_start_q;
    assign busy       = busy_q;
    assign blk_done   = blk_done_q;
    assign err        = err_q;
    assign err_phase  = err_phase_q;
    assign blk_cnt    = blk_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/simon_seq_ctrl.md
Name: simon_seq_ctrl

Overview:
Top-level sequencer for the Simon encryption chip. It orders the three phases: serial load (input_taker), encryption (simon core), and serial drain (cipher output_giver plus plaintext echo output_giver). It replaces the chained done-to-start wiring with an explicit FSM that adds per-phase watchdogs, abort, a completed-block counter and a state debug bus for the test pads.

Parameters:
CNT_W, 10, width of the per-phase watchdog counter
LOAD_TO, 64, max cycles in LOAD before error
CRYPT_TO, 512, max cycles in CRYPT before error
DRAIN_TO, 64, max cycles in DRAIN before error
BLK_W, 4, width of the completed-block counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  external start request (level; rising edge is used)
abort  in  1  synchronous abort, returns FSM to IDLE
in_done  in  1  load complete (input_taker done)
core_done  in  1  encryption complete (simon core done)
out_done  in  1  cipher stream complete
txt_done  in  1  plaintext echo stream complete
in_en  out  1  level, high throughout LOAD
core_start  out  1  one-cycle pulse that starts the core
out_start  out  1  one-cycle pulse that starts both output_givers
busy  out  1  high in LOAD, CRYPT and DRAIN
blk_done  out  1  one-cycle pulse when a block fully completes
err  out  1  sticky watchdog error flag
err_phase  out  2  phase that timed out: 1 LOAD, 2 CRYPT, 3 DRAIN
blk_cnt  out  BLK_W  completed-block count
state_dbg  out  3  current state encoding, for test pads

Behaviour:
- All outputs are registered. During reset (reset=0) every output is 0, the state is IDLE, start_q=0, both drain latches=0 and the counter=0.
- State encoding: IDLE=0, LOAD=1, CRYPT=2, DRAIN=3, DONE=4, ERR=5.
- Rising-edge detect: start_rise = start & ~start_q, where start_q is registered every cycle.
- IDLE: on start_rise, go to LOAD next cycle; in_en goes high in that same cycle.
- LOAD: on in_done, go to CRYPT and drop in_en; core_start is high for exactly the first CRYPT cycle.
- CRYPT: on core_done, go to DRAIN; out_start is high for exactly the first DRAIN cycle.
- DRAIN:
  - Separate sticky latches record out_done and txt_done; the two may arrive in any order or in the same cycle.
  - When both latches are set (including a latch being set this cycle), go to DONE.
  - Latches clear on leaving DRAIN.
- DONE: lasts one cycle. blk_done=1 and blk_cnt increments in that cycle; blk_cnt wraps from 2^BLK_W-1 to 0. Next state is IDLE.
- Watchdog:
  - The counter clears on every state change and increments each cycle spent in LOAD, CRYPT or DRAIN.
  - If it reaches phase_TO-1 and the expected event is absent that cycle, go to ERR; err=1 and err_phase records the phase.
  - If the event and the timeout coincide, the event wins.
- ERR:
  - in_en and busy are 0; no pulses are issued; start is ignored.
  - Leave only via abort (to IDLE, clearing err and err_phase) or reset.
- abort:
  - Highest priority. From any state, go to IDLE next cycle, clearing the counter, latches and pulses.
  - blk_cnt is preserved; blk_done is not raised.
- Done inputs arriving outside their own phase (e.g. core_done in LOAD) are ignored.
- start_rise outside IDLE is ignored. A start held high through DONE does not retrigger unless SIMON_SEQ_AUTORESTART_EN is defined.
- Latency from start rise to core_start: 1 + (LOAD cycles) + 1.

Optional Feature:
SIMON_SEQ_AUTORESTART_EN:
- Defined: in DONE, if start=1 (level), the next state is LOAD instead of IDLE. This gives back-to-back blocks without a start low/high toggle, and busy stays high except in the DONE cycle.
- Undefined: DONE always goes to IDLE, and a new block needs a fresh start rising edge.

Decomposition:
- Package simon_seq_pkg holds:
  - the state enum (3-bit) and its encodings;
  - the err_phase codes (PH_LOAD=1, PH_CRYPT=2, PH_DRAIN=3);
  - the default timeout constants.
- One sub-module, simon_seq_wdog: a loadable cycle counter with clear, enable and limit inputs and a terminal output. The FSM remains in simon_seq_ctrl.

Test Plan:
- Nominal block:
  - Stimulus: start rise at cycle 10; in_done at cycle 20; core_done at cycle 60; out_done at cycle 70; txt_done at cycle 72.
  - Response: in_en high for cycles 11-20; core_start pulse at cycle 21; out_start pulse at cycle 61; blk_done pulse at cycle 73; blk_cnt goes 0->1; state_dbg sequence 0,1,2,3,4,0.
- Simultaneous drain: out_done and txt_done asserted in the same cycle -> DONE on the next cycle; exactly one blk_done pulse.
- Watchdog: LOAD_TO=64 and in_done never arrives -> ERR after 64 LOAD cycles with err=1, err_phase=1; start is then ignored; abort returns to IDLE with err=0. Repeat with in_done arriving on the terminal cycle -> CRYPT, no error.
- Abort mid-CRYPT: abort at cycle 40 -> IDLE at cycle 41; the later core_done is ignored; blk_cnt unchanged; no out_start.
- Reset mid-DRAIN: reset=0 asynchronously -> all outputs 0 immediately and blk_cnt=0; after release the FSM waits for a new start rise.
- Wrap and autorestart: run 16 blocks with BLK_W=4 -> blk_cnt returns to 0. With SIMON_SEQ_AUTORESTART_EN and start held at 1 -> DONE goes directly to LOAD; without the macro -> IDLE until start toggles.
